// File: rtl/ddc_decim4_fir.sv
// ddc_decim4_fir: 40-tap real FIR with decimate-by-4 on a single time-shared MAC.
// Samples go into a circular delay line (TAPS+DECIM deep). Every DECIM-th valid
// sample starts one TAPS-cycle MAC pass. The result is rounded, shifted and
// saturated, then presented as a one-cycle strobe TAPS+4 clocks after the trigger.
// Coefficients sit in a RAM that can be written at run time or bulk-cleared.
module ddc_decim4_fir #(
  parameter int TAPS      = 40,
  parameter int DECIM     = 4,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic [15:0]   coef_wr_addr,
  input  logic [CW-1:0] coef_wr_data,
  input  logic          coef_wr_en,
  input  logic          coef_clr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int DEPTH = TAPS + DECIM;
  localparam int PW    = $clog2(DEPTH);
  localparam int CAW   = $clog2(TAPS);
  localparam int FW    = $clog2(TAPS + 1);
  localparam int SW    = $clog2(TAPS + 3);
  localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PRW   = DW + CW;
  localparam int AW    = PRW + 6;

  localparam logic [PW-1:0]  LAST_SLOT   = PW'(DEPTH - 1);
  localparam logic [PW-1:0]  DEPTH_P     = PW'(DEPTH);
  localparam logic [FW-1:0]  FILL_MAX    = FW'(TAPS);
  localparam logic [PHW-1:0] PHASE_LAST  = PHW'(DECIM - 1);
  localparam logic [SW-1:0]  STEP_RD_END = SW'(TAPS);
  localparam logic [SW-1:0]  STEP_LAST   = SW'(TAPS + 2);
  localparam logic [SW-1:0]  CLR_LAST    = SW'(TAPS - 1);
  localparam logic [CAW-1:0] K_LAST      = CAW'(TAPS - 1);
  localparam logic [15:0]    TAPS_A      = 16'(TAPS);

  localparam logic signed [AW-1:0] RND     = AW'(2 ** (OUT_SHIFT - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_CLEAR} state_t;

  state_t state;
  logic [SW-1:0]  step;
  logic           clr_pend;
  logic [PW-1:0]  base_ptr;
  logic [FW-1:0]  fill_snap;
  logic [DW-1:0]  res_reg;

  logic [PHW-1:0] phase;
  logic [PW-1:0]  wr_ptr;
  logic [FW-1:0]  fill;
  logic           trigger;

  logic signed [CW-1:0] coef_mem [TAPS];
  logic signed [DW-1:0] dl_mem [DEPTH];

  logic                 coef_we;
  logic [CAW-1:0]       coef_waddr;
  logic signed [CW-1:0] coef_wdata;

  logic [CAW-1:0]       rd_k;
  logic [PW-1:0]        rd_addr;
  logic                 rd_issue;
  logic signed [CW-1:0] coef_q;
  logic signed [DW-1:0] data_q;
  logic                 rd_vld;
  logic                 rd_live;
  logic signed [PRW-1:0] prod_reg;
  logic                 prod_vld;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_rnd;
  logic signed [AW-1:0] acc_sh;
  logic [DW-1:0]        sat_val;

  assign trigger = din_valid && (phase == PHASE_LAST);

  // Coefficient write port: CLEAR sweeps zeros and locks out host writes.
  always_comb begin
    coef_we    = 1'b0;
    coef_waddr = coef_wr_addr[CAW-1:0];
    coef_wdata = coef_wr_data;
    if (state == S_CLEAR) begin
      coef_we    = 1'b1;
      coef_waddr = CAW'(step);
      coef_wdata = '0;
    end else if (coef_wr_en && (coef_wr_addr < TAPS_A)) begin
      coef_we = 1'b1;
    end
  end

  // Coefficient RAM write.
  always_ff @(posedge clkin) begin
    if (coef_we) coef_mem[coef_waddr] <= coef_wdata;
  end

  // Taps are visited oldest first (k = TAPS-1 down to 0): with a sample
  // arriving every clock the oldest slots are the first to be recycled,
  // so reading them first keeps the window intact with only DECIM spare slots.
  always_comb begin
    rd_k     = K_LAST - CAW'(step);
    rd_issue = (state == S_MAC) && (step < STEP_RD_END);
    if (base_ptr >= PW'(rd_k)) rd_addr = base_ptr - PW'(rd_k);
    else                       rd_addr = base_ptr + DEPTH_P - PW'(rd_k);
  end

  // Coefficient RAM registered read.
  always_ff @(posedge clkin) begin
    coef_q <= coef_mem[rd_k];
  end

  // Delay-line write; a write during reset only lands in slot 0, which the
  // first post-reset sample overwrites before any tap can use it.
  always_ff @(posedge clkin) begin
    if (din_valid) dl_mem[wr_ptr] <= din;
  end

  // Delay-line registered read.
  always_ff @(posedge clkin) begin
    data_q <= dl_mem[rd_addr];
  end

  // Input-side bookkeeping: decimation phase, write pointer, fill level.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (din_valid) begin
      phase  <= (phase == PHASE_LAST) ? '0 : phase + PHW'(1);
      wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
      if (fill != FILL_MAX) fill <= fill + FW'(1);
    end
  end

  // MAC pipeline: read -> product -> accumulate; taps older than the fill level count as 0.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rd_vld   <= 1'b0;
      rd_live  <= 1'b0;
      prod_vld <= 1'b0;
      prod_reg <= '0;
      acc      <= '0;
    end else begin
      rd_vld   <= rd_issue;
      rd_live  <= rd_issue && (FW'(rd_k) < fill_snap);
      prod_vld <= rd_vld;
      if (rd_live) prod_reg <= coef_q * data_q;
      else         prod_reg <= '0;
      if ((state == S_IDLE) && trigger) acc <= '0;
      else if (prod_vld)                acc <= acc + AW'(prod_reg);
    end
  end

  // Round half up, arithmetic shift, then clamp to the output range.
  always_comb begin
    acc_rnd = acc + RND;
    acc_sh  = acc_rnd >>> OUT_SHIFT;
    if (acc_sh > SAT_MAX)      sat_val = {1'b0, {(DW-1){1'b1}}};
    else if (acc_sh < SAT_MIN) sat_val = {1'b1, {(DW-1){1'b0}}};
    else                       sat_val = acc_sh[DW-1:0];
  end

  // Control FSM with registered outputs: IDLE, MAC pass, output strobe, coefficient clear.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      step       <= '0;
      clr_pend   <= 1'b0;
      base_ptr   <= '0;
      fill_snap  <= '0;
      res_reg    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (coef_clr) clr_pend <= 1'b1;
      if (trigger && (state != S_IDLE)) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state     <= S_MAC;
            step      <= '0;
            base_ptr  <= wr_ptr;
            fill_snap <= (fill == FILL_MAX) ? fill : fill + FW'(1);
            busy      <= 1'b1;
          end else if (clr_pend) begin
            state    <= S_CLEAR;
            step     <= '0;
            clr_pend <= coef_clr;
            busy     <= 1'b1;
          end
        end
        S_MAC: begin
          if (step == STEP_LAST) begin
            state   <= S_OUT;
            res_reg <= sat_val;
            busy    <= 1'b0;
          end else begin
            step <= step + SW'(1);
          end
        end
        S_OUT: begin
          dout       <= res_reg;
          dout_valid <= 1'b1;
          state      <= S_IDLE;
        end
        S_CLEAR: begin
          if (step == CLR_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddc_decim4_fir.sv
// Directed bench for ddc_decim4_fir: impulse, saturation, rounding, overrun,
// coefficient clear and reset-abort scenarios, each checked with immediate assertions.
module tb_ddc_decim4_fir;

  logic        clkin = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic [15:0] coef_wr_addr;
  logic [15:0] coef_wr_data;
  logic        coef_wr_en;
  logic        coef_clr;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        overrun;

  ddc_decim4_fir dut (
    .clkin        (clkin),
    .reset        (reset),
    .din          (din),
    .din_valid    (din_valid),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_wr_en   (coef_wr_en),
    .coef_clr     (coef_clr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int val;
    int ecyc;
  } strobe_t;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      edge_cnt = 0;
  int      edge_last = 0;
  int      nsamp = 0;
  int      hist [1024];
  int      cm [40];
  strobe_t sq [$];

  // Count rising edges; edge index p is the (p+1)-th posedge.
  always @(posedge clkin) edge_cnt <= edge_cnt + 1;

  // Record every output strobe with the edge index that produced it.
  always @(posedge clkin) begin : mon
    strobe_t s;
    #1;
    if (dout_valid) begin
      s.val  = int'($signed(dout));
      s.ecyc = edge_cnt - 1;
      sq.push_back(s);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic load_coef(input int k, input int v);
    @(negedge clkin);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 16'(k);
    coef_wr_data = 16'(v);
    if (k < 40) cm[k] = v;
  endtask

  task automatic wr_off();
    @(negedge clkin);
    coef_wr_en = 1'b0;
  endtask

  task automatic send(input int v);
    @(negedge clkin);
    din       = 16'(v);
    din_valid = 1'b1;
    hist[nsamp] = v;
    nsamp++;
    edge_last = edge_cnt;
  endtask

  task automatic valid_off();
    @(negedge clkin);
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clkin);
    reset = 1'b1;
    din_valid = 1'b0;
    coef_wr_en = 1'b0;
    coef_clr = 1'b0;
    repeat (3) @(negedge clkin);
    reset = 1'b0;
    nsamp = 0;
    sq.delete();
  endtask

  task automatic wait_strobe(input string tag, output strobe_t s);
    int got;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin);
      if (sq.size() > 0) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_seen"}, got, 1);
    if (got == 1) s = sq.pop_front();
    else begin
      s.val  = 0;
      s.ecyc = 0;
    end
  endtask

  // Direct-form reference: sum over samples since reset, round, shift, clamp.
  function automatic int model(input int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < 40; k++)
      if (n - k >= 0) acc += longint'(cm[k]) * longint'(hist[n - k]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  initial begin : stim
    strobe_t s;
    int t_trig;
    int busy_cnt;
    int rnd_in [4];
    int rnd_exp [4];

    reset = 1'b1; din = '0; din_valid = 1'b0;
    coef_wr_addr = '0; coef_wr_data = '0; coef_wr_en = 1'b0; coef_clr = 1'b0;
    t_trig = 0;
    repeat (3) @(negedge clkin);
    chk("rst_dout", $signed(dout), 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clkin);
    reset = 1'b0;
    nsamp = 0;

    // Impulse: coef[k]=2(k+1), one sample of 16384 then zeros, 50 clocks apart.
    for (int k = 0; k < 40; k++) load_coef(k, 2 * (k + 1));
    wr_off();
    for (int i = 0; i < 48; i++) begin
      send((i == 0) ? 16384 : 0);
      if (i == 3) t_trig = edge_last;
      valid_off();
      if (i == 3) chk("imp_busy", busy, 1);
      idle(48);
    end
    idle(60);
    chk("imp_count", sq.size(), 12);
    for (int j = 0; j < 12; j++) begin
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk($sformatf("imp_y%0d", j), s.val, (j < 10) ? 4 * (j + 1) : 0);
        if (j == 0) chk("imp_latency", s.ecyc - t_trig, 44);
      end
    end
    chk("imp_overrun", overrun, 0);

    // Saturation, positive then negative (fresh reset for the negative case).
    do_reset();
    for (int k = 0; k < 40; k++) load_coef(k, 32767);
    wr_off();
    for (int i = 0; i < 8; i++) send(32767);
    valid_off();
    wait_strobe("sat_pos", s);
    chk("sat_pos", s.val, 32767);
    chk("sat_overrun", overrun, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send(-32768);
    valid_off();
    wait_strobe("sat_neg", s);
    chk("sat_neg", s.val, -32768);

    // Rounding with coef[0]=1; the write to address 64 must be ignored.
    do_reset();
    for (int k = 0; k < 40; k++) load_coef(k, (k == 0) ? 1 : 0);
    load_coef(64, 30000);
    wr_off();
    rnd_in[0] = 16384;  rnd_exp[0] = 1;
    rnd_in[1] = -16384; rnd_exp[1] = 0;
    rnd_in[2] = 16383;  rnd_exp[2] = 0;
    rnd_in[3] = -16385; rnd_exp[3] = -1;
    for (int r = 0; r < 4; r++) begin
      send(0); send(0); send(0); send(rnd_in[r]);
      valid_off();
      wait_strobe($sformatf("rnd%0d", r), s);
      chk($sformatf("rnd%0d", r), s.val, rnd_exp[r]);
    end

    // Overrun: continuous input; accepted triggers at samples 3, 51, 99, 147.
    do_reset();
    for (int k = 0; k < 40; k++) load_coef(k, ((k * 37) % 200) - 100);
    wr_off();
    for (int i = 0; i < 160; i++) begin
      send(((i * 2731 + 1234) % 65536) - 32768);
      if (i == 3) t_trig = edge_last;
      if (i == 7) chk("ovr_before", overrun, 0);
      if (i == 8) chk("ovr_after", overrun, 1);
    end
    valid_off();
    idle(60);
    chk("ovr_count", sq.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk($sformatf("ovr_y%0d", j), s.val, model(3 + 48 * j));
        chk($sformatf("ovr_t%0d", j), s.ecyc - t_trig, 44 + 48 * j);
      end
    end

    // Reset in the middle of a MAC pass: outputs clear at once, no strobe.
    for (int i = 0; i < 4; i++) send(5000 + i);
    valid_off();
    idle(10);
    @(negedge clkin);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_dout", $signed(dout), 0);
    chk("arst_dout_valid", dout_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    repeat (3) @(negedge clkin);
    reset = 1'b0;
    nsamp = 0;
    idle(60);
    chk("arst_no_strobe", sq.size(), 0);
    send(1000); send(2000); send(3000); send(4000);
    valid_off();
    wait_strobe("fill_mask", s);
    chk("fill_mask", s.val, model(3));

    // coef_clr during MAC: current result uses old coefficients, then a 40-clock clear.
    send(500); send(-700); send(900); send(16384);
    valid_off();
    idle(5);
    @(negedge clkin); coef_clr = 1'b1;
    @(negedge clkin); coef_clr = 1'b0;
    wait_strobe("clr_old", s);
    chk("clr_old", s.val, model(7));
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin);
      coef_wr_en   = (i == 10);
      coef_wr_addr = 16'd0;
      coef_wr_data = 16'd5000;
      if (busy) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    coef_wr_en = 1'b0;
    chk("clr_busy_len", busy_cnt, 40);
    for (int k = 0; k < 40; k++) cm[k] = 0;
    send(0); send(0); send(0); send(16384);
    valid_off();
    wait_strobe("clr_new", s);
    chk("clr_new", s.val, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
